// File: rtl/sw_m_to_n_buf_pkg.sv
// sw_pkg: shared constants, FIFO entry type and round-robin helper
// for the sw_m_to_n_buf buffered crossbar.
package sw_pkg;

    localparam int SW_IN_N  = 5;
    localparam int SW_OUT_N = 5;
    localparam int SW_TAG_W = 32;
    localparam int SW_DEPTH = 4;
    localparam int SW_W     = $clog2(SW_OUT_N);
    localparam int SW_IN_W  = $clog2(SW_IN_N);

    // One buffered beat: destination output index plus payload.
    typedef struct packed {
        logic [SW_W-1:0]     swb;
        logic [SW_TAG_W-1:0] tag;
    } sw_entry_t;

    // Arbiter result: any grant, its index and its one-hot form.
    typedef struct packed {
        logic               vld;
        logic [SW_IN_W-1:0] idx;
        logic [SW_IN_N-1:0] oh;
    } sw_gnt_t;

    // Search starts one past the last granted input and wraps
    // from SW_IN_N-1 back to 0.
    function automatic sw_gnt_t sw_rr_next(
        input logic [SW_IN_W-1:0] ptr,
        input logic [SW_IN_N-1:0] req
    );
        sw_gnt_t g;
        int      cand;
        g = '0;
        for (int k = 1; k <= SW_IN_N; k++) begin
            cand = (int'(ptr) + k) % SW_IN_N;
            if (!g.vld && req[cand]) begin
                g.vld      = 1'b1;
                g.idx      = SW_IN_W'(cand);
                g.oh[cand] = 1'b1;
            end
        end
        return g;
    endfunction

endpackage

// File: rtl/sw_m_to_n_buf_if.sv
// sw_m_to_n_buf_if: upstream and downstream handshake bundle.
// slave = switch view, master = traffic source/sink view.
interface sw_m_to_n_buf_if;
    import sw_pkg::*;

    logic [SW_IN_N-1:0]                 upreq_i;
    logic [SW_IN_N-1:0][SW_W-1:0]       up_swb_i;
    logic [SW_IN_N-1:0][SW_TAG_W-1:0]   uptag_i;
    logic [SW_IN_N-1:0]                 uprdy_o;
    logic [SW_OUT_N-1:0]                dnreq_o;
    logic [SW_OUT_N-1:0][SW_TAG_W-1:0]  dntag_o;
    logic [SW_OUT_N-1:0]                dnrdy_i;
    logic                               err_o;

    modport slave (
        input  upreq_i, up_swb_i, uptag_i, dnrdy_i,
        output uprdy_o, dnreq_o, dntag_o, err_o
    );

    modport master (
        output upreq_i, up_swb_i, uptag_i, dnrdy_i,
        input  uprdy_o, dnreq_o, dntag_o, err_o
    );

endinterface

// File: rtl/sw_m_to_n_buf_fifo.sv
// sw_fifo: DEPTH-entry synchronous FIFO, pointers wrap modulo DEPTH.
// Ports: clk, rst_n, push, pop, din, dout (head), empty, full.
module sw_fifo #(
    parameter int DW    = 8,
    parameter int DEPTH = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic          pop,
    input  logic [DW-1:0] din,
    output logic [DW-1:0] dout,
    output logic          empty,
    output logic          full
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DW-1:0] mem_q [DEPTH];
    logic [AW-1:0] wr_q;
    logic [AW-1:0] rd_q;
    logic [CW-1:0] cnt_q;
    logic          do_push;
    logic          do_pop;

    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (do_push) wr_q <= wr_q + AW'(1);
            if (do_pop)  rd_q <= rd_q + AW'(1);
            cnt_q <= cnt_q + CW'(do_push) - CW'(do_pop);
        end
    end

    // Storage needs no reset: the count alone defines validity.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q] <= din;
    end

    assign dout  = mem_q[rd_q];
    assign empty = (cnt_q == '0);
    assign full  = (cnt_q == CW'(DEPTH));

endmodule

// File: rtl/sw_m_to_n_buf.sv
// sw_m_to_n_buf: buffered IN_N x OUT_N crossbar with a FIFO per input
// and a round-robin arbiter with stable grant per output.
// Ports: clk, rst_n (async active-low), bus (sw_m_to_n_buf_if.slave).
// Macro SW_PKT_LOCK_EN: an output stays locked to one input until a
// beat with tag[TAG_W-1] = 1 (last) handshakes.
module sw_m_to_n_buf
    import sw_pkg::*;
(
    input logic            clk,
    input logic            rst_n,
    sw_m_to_n_buf_if.slave bus
);

    localparam int IN_N  = SW_IN_N;
    localparam int OUT_N = SW_OUT_N;
    localparam int TAG_W = SW_TAG_W;
    localparam int DEPTH = SW_DEPTH;
    localparam int IN_W  = SW_IN_W;

    sw_entry_t [IN_N-1:0]       din;
    sw_entry_t [IN_N-1:0]       head;
    logic [IN_N-1:0]            empty;
    logic [IN_N-1:0]            full;
    logic [IN_N-1:0]            push;
    logic [IN_N-1:0]            pop;
    logic [IN_N-1:0]            bad;
    logic [OUT_N-1:0][IN_N-1:0] req;
    logic [OUT_N-1:0][IN_N-1:0] gnt_oh;
    logic [OUT_N-1:0]           hs;
    logic                       err_q;

    genvar gi, go;

    for (gi = 0; gi < IN_N; gi++) begin : g_in
        assign push[gi]    = bus.upreq_i[gi] & ~full[gi];
        assign din[gi].swb = bus.up_swb_i[gi];
        assign din[gi].tag = bus.uptag_i[gi];

        // Out-of-range heads are dropped without arbitration.
        assign bad[gi] = ~empty[gi] &
                         (int'(head[gi].swb) >= OUT_N);

        sw_fifo #(
            .DW    ($bits(sw_entry_t)),
            .DEPTH (DEPTH)
        ) u_fifo (
            .clk   (clk),
            .rst_n (rst_n),
            .push  (push[gi]),
            .pop   (pop[gi]),
            .din   (din[gi]),
            .dout  (head[gi]),
            .empty (empty[gi]),
            .full  (full[gi])
        );

        for (go = 0; go < OUT_N; go++) begin : g_req
            assign req[go][gi] = ~empty[gi] &
                                 (int'(head[gi].swb) == go);
        end
    end

    for (go = 0; go < OUT_N; go++) begin : g_out
        logic [IN_W-1:0] rr_q;
        logic            hold_vld_q;
        logic [IN_W-1:0] hold_idx_q;
        sw_gnt_t         rr_g;
        logic            vld;
        logic [IN_W-1:0] idx;
        logic [IN_N-1:0] oh;
`ifdef SW_PKT_LOCK_EN
        logic            lock_vld_q;
        logic [IN_W-1:0] lock_idx_q;
`endif

        assign rr_g = sw_rr_next(rr_q, req[go]);

        // Priority: held grant, then packet lock, then round-robin.
        always_comb begin
            vld = rr_g.vld;
            idx = rr_g.idx;
            oh  = rr_g.oh;
`ifdef SW_PKT_LOCK_EN
            if (lock_vld_q) begin
                vld = req[go][lock_idx_q];
                idx = lock_idx_q;
                oh  = IN_N'(1) << lock_idx_q;
            end
`endif
            // A held head cannot pop, so its request is still live.
            if (hold_vld_q) begin
                vld = 1'b1;
                idx = hold_idx_q;
                oh  = IN_N'(1) << hold_idx_q;
            end
        end

        assign gnt_oh[go]      = oh;
        assign hs[go]          = vld & bus.dnrdy_i[go];
        assign bus.dnreq_o[go] = vld;
        assign bus.dntag_o[go] = vld ? head[idx].tag : '0;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                rr_q       <= IN_W'(IN_N - 1);
                hold_vld_q <= 1'b0;
                hold_idx_q <= '0;
            end else begin
                hold_vld_q <= vld & ~bus.dnrdy_i[go];
                hold_idx_q <= idx;
                if (hs[go]) rr_q <= idx;
            end
        end

`ifdef SW_PKT_LOCK_EN
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                lock_vld_q <= 1'b0;
                lock_idx_q <= '0;
            end else if (hs[go]) begin
                lock_vld_q <= ~head[idx].tag[TAG_W-1];
                lock_idx_q <= idx;
            end
        end
`endif
    end

    // Each head targets one output, so at most one pop per input.
    always_comb begin
        pop = bad;
        for (int o = 0; o < OUT_N; o++) begin
            if (hs[o]) pop = pop | gnt_oh[o];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else if (|bad) begin
            err_q <= 1'b1;
        end
    end

    assign bus.uprdy_o = ~full;
    assign bus.err_o   = err_q;

endmodule

// File: tb/tb_sw_m_to_n_buf.sv
// tb_sw_m_to_n_buf: vector table plus directed sequences with a
// per-(input,output) scoreboard checked at every downstream handshake.
module tb_sw_m_to_n_buf;
    import sw_pkg::*;

    localparam int IN_N  = SW_IN_N;
    localparam int OUT_N = SW_OUT_N;
    localparam int TW    = SW_TAG_W;
`ifdef SW_PKT_LOCK_EN
    localparam logic [TW-1:0] TAG_LAST = {1'b1, {(TW-1){1'b0}}};
`else
    localparam logic [TW-1:0] TAG_LAST = '0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    sw_m_to_n_buf_if bus ();

    sw_m_to_n_buf dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_chk = 0;
    int n_fail = 0;
    logic [TW-1:0] sb [IN_N*OUT_N][$];
    int hs_src [OUT_N][$];
    int seq [IN_N];

    typedef struct {
        int             src;
        int             swb;
        logic [TW-1:0]  tag;
        logic [OUT_N-1:0] exp_req;
        logic           exp_err;
    } vec_t;

    vec_t tv [6];

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [TW-1:0] mk_tag(input int i, input int s,
                                             input logic last);
        return {last, 15'h0, 4'(i), 12'(s)};
    endfunction

    function automatic int sb_total();
        int n = 0;
        for (int k = 0; k < IN_N*OUT_N; k++) n += sb[k].size();
        return n;
    endfunction

    // Scoreboard: pop on handshake, then record newly accepted beats.
    always @(negedge clk) begin : mon
        int s;
        int d;
        if (!rst_n) begin
            for (int k = 0; k < IN_N*OUT_N; k++) sb[k].delete();
        end else begin
            for (int o = 0; o < OUT_N; o++) begin
                if (bus.dnreq_o[o] && bus.dnrdy_i[o]) begin
                    s = int'(bus.dntag_o[o][15:12]);
                    hs_src[o].push_back(s);
                    if (s >= IN_N || sb[s*OUT_N+o].size() == 0) begin
                        n_chk++;
                        n_fail++;
                        $display("FAIL sb_unexpected: out %0d got %0h expected none",
                                 o, bus.dntag_o[o]);
                    end else begin
                        chk("sb_tag", bus.dntag_o[o],
                            sb[s*OUT_N+o].pop_front());
                    end
                end else if (!bus.dnreq_o[o]) begin
                    chk("idle_tag_zero", bus.dntag_o[o], 0);
                end
            end
            for (int i = 0; i < IN_N; i++) begin
                d = int'(bus.up_swb_i[i]);
                if (bus.upreq_i[i] && bus.uprdy_o[i] && d < OUT_N)
                    sb[i*OUT_N+d].push_back(bus.uptag_i[i]);
            end
        end
    end

    task automatic idle_inputs();
        bus.upreq_i  = '0;
        bus.up_swb_i = '0;
        bus.uptag_i  = '0;
    endtask

    task automatic next_drive();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        idle_inputs();
        bus.dnrdy_i = '1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int o = 0; o < OUT_N; o++) hs_src[o].delete();
        for (int i = 0; i < IN_N; i++) seq[i] = 0;
        next_drive();
    endtask

    task automatic drain(input string nm);
        int t = 0;
        while (sb_total() != 0 && t < 200) begin
            @(negedge clk);
            t++;
        end
        chk(nm, sb_total(), 0);
        next_drive();
    endtask

    task automatic drive1(input int i, input int swb,
                          input logic [TW-1:0] tag);
        bus.upreq_i[i]  = 1'b1;
        bus.up_swb_i[i] = SW_W'(swb);
        bus.uptag_i[i]  = tag;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        tv[0] = '{0, 2, TAG_LAST | 32'h0000_00A5, 5'b00100, 1'b0};
        tv[1] = '{1, 0, mk_tag(1, 1, 1'b1), 5'b00001, 1'b0};
        tv[2] = '{4, 4, mk_tag(4, 1, 1'b1), 5'b10000, 1'b0};
        tv[3] = '{3, 1, mk_tag(3, 1, 1'b1), 5'b00010, 1'b0};
        tv[4] = '{2, 3, mk_tag(2, 1, 1'b1), 5'b01000, 1'b0};
        tv[5] = '{1, 7, mk_tag(1, 2, 1'b1), 5'b00000, 1'b1};

        idle_inputs();
        bus.dnrdy_i = '1;
        do_reset();

        // Reset values
        @(negedge clk);
        chk("rst_uprdy", bus.uprdy_o, 5'h1F);
        chk("rst_dnreq", bus.dnreq_o, 0);
        chk("rst_dntag", bus.dntag_o, 0);
        chk("rst_err", bus.err_o, 0);
        next_drive();

        // Single-beat vector table
        for (int k = 0; k < 6; k++) begin
            idle_inputs();
            drive1(tv[k].src, tv[k].swb, tv[k].tag);
            @(negedge clk);
            chk("tv_accept", bus.uprdy_o[tv[k].src], 1);
            next_drive();
            idle_inputs();
            @(negedge clk);
            chk("tv_dnreq", bus.dnreq_o, tv[k].exp_req);
            if (tv[k].swb < OUT_N)
                chk("tv_dntag", bus.dntag_o[tv[k].swb], tv[k].tag);
            next_drive();
            @(negedge clk);
            chk("tv_err", bus.err_o, tv[k].exp_err);
            chk("tv_drained", bus.dnreq_o, 0);
            next_drive();
        end

        // Sticky error, then asynchronous reset mid-stream
        repeat (3) next_drive();
        @(negedge clk);
        chk("err_sticky", bus.err_o, 1);
        next_drive();
        bus.dnrdy_i = '0;
        for (int c = 0; c < 3; c++) begin
            for (int i = 0; i < IN_N; i++)
                drive1(i, i, mk_tag(i, 8 + c, 1'b1));
            @(negedge clk);
            next_drive();
        end
        idle_inputs();
        chk("pre_rst_dnreq", bus.dnreq_o, 5'h1F);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_uprdy", bus.uprdy_o, 5'h1F);
        chk("arst_dnreq", bus.dnreq_o, 0);
        chk("arst_dntag", bus.dntag_o, 0);
        chk("arst_err", bus.err_o, 0);
        do_reset();

        // Fairness: all inputs stream to output 1
        for (int c = 0; c < 15; c++) begin
            for (int i = 0; i < IN_N; i++)
                drive1(i, 1, mk_tag(i, seq[i], 1'b1));
            @(negedge clk);
            for (int i = 0; i < IN_N; i++)
                if (bus.uprdy_o[i]) seq[i]++;
            next_drive();
        end
        idle_inputs();
        chk("fair_count", hs_src[1].size(), 14);
        for (int k = 0; k < 10; k++)
            chk("fair_order",
                (k < hs_src[1].size()) ? hs_src[1][k] : -1, k % 5);
        drain("fair_drain");

        // Back-pressure / fill on input 2 towards output 0
        do_reset();
        bus.dnrdy_i = 5'b11110;
        for (int b = 0; b < 4; b++) begin
            drive1(2, 0, mk_tag(2, b, 1'b1));
            @(negedge clk);
            chk("fill_rdy", bus.uprdy_o[2], 1);
            next_drive();
        end
        idle_inputs();
        @(negedge clk);
        chk("full_rdy_low", bus.uprdy_o[2], 0);
        chk("bp_dnreq", bus.dnreq_o[0], 1);
        chk("bp_tag", bus.dntag_o[0], mk_tag(2, 0, 1'b1));
        next_drive();
        bus.dnrdy_i = '1;
        @(negedge clk);
        chk("rdy_low_at_pop", bus.uprdy_o[2], 0);
        next_drive();
        @(negedge clk);
        chk("rdy_back", bus.uprdy_o[2], 1);
        next_drive();
        drain("bp_drain");
        chk("bp_count", hs_src[0].size(), 4);

        // Grant stability on output 3
        do_reset();
        bus.dnrdy_i = 5'b10111;
        drive1(4, 3, mk_tag(4, 0, 1'b1));
        @(negedge clk);
        next_drive();
        idle_inputs();
        drive1(0, 3, mk_tag(0, 0, 1'b1));
        @(negedge clk);
        chk("gs_first", bus.dntag_o[3], mk_tag(4, 0, 1'b1));
        next_drive();
        idle_inputs();
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            chk("gs_hold_req", bus.dnreq_o[3], 1);
            chk("gs_hold_tag", bus.dntag_o[3], mk_tag(4, 0, 1'b1));
            next_drive();
        end
        bus.dnrdy_i = '1;
        @(negedge clk);
        chk("gs_release", bus.dntag_o[3], mk_tag(4, 0, 1'b1));
        next_drive();
        @(negedge clk);
        chk("gs_next_req", bus.dnreq_o[3], 1);
        chk("gs_next_tag", bus.dntag_o[3], mk_tag(0, 0, 1'b1));
        next_drive();
        drain("gs_drain");

`ifdef SW_PKT_LOCK_EN
        // 3-beat packet from input 0 competes with input 1
        do_reset();
        drive1(0, 0, mk_tag(0, 0, 1'b0));
        drive1(1, 0, mk_tag(1, 0, 1'b1));
        @(negedge clk);
        next_drive();
        idle_inputs();
        drive1(0, 0, mk_tag(0, 1, 1'b0));
        @(negedge clk);
        next_drive();
        idle_inputs();
        drive1(0, 0, mk_tag(0, 2, 1'b1));
        @(negedge clk);
        next_drive();
        idle_inputs();
        drain("lock_drain");
        chk("lock_count", hs_src[0].size(), 4);
        for (int k = 0; k < 4; k++)
            chk("lock_order",
                (k < hs_src[0].size()) ? hs_src[0][k] : -1,
                (k < 3) ? 0 : 1);
`endif

        chk("sb_empty", sb_total(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/sw_m_to_n_buf.md
# sw_m_to_n_buf

Buffered IN_N x OUT_N crossbar switch for the NOC fabric, and the successor to the unbuffered M-to-N switch. Each input port has a DEPTH-entry FIFO. Each output port has a fair round-robin arbiter with a stable grant. An optional packet-lock mode keeps a grant for the whole of a multi-beat packet. The block sits between router input stages and downstream links, and decouples upstream ready from downstream back-pressure.

## Interface
- IN_N, 5, number of input ports (≥2)
- OUT_N, 5, number of output ports (≥2)
- TAG_W, 32, payload/tag width in bits (≥2)
- DEPTH, 4, per-input FIFO depth in entries; power of two, ≥2
- SW_W, $clog2(OUT_N), width of the route select field
- clk  in  1  clock
- rst_n  in  1  reset; asynchronous, active-low
- upreq_i  in  IN_N  per-input valid
- up_swb_i  in  IN_N x SW_W  per-input destination output index
- uptag_i  in  IN_N x TAG_W  per-input payload
- uprdy_o  out  IN_N  per-input ready
- dnreq_o  out  OUT_N  per-output valid
- dntag_o  out  OUT_N x TAG_W  per-output payload
- dnrdy_i  in  OUT_N  per-output ready
- err_o  out  1  sticky flag: a beat was received with up_swb_i ≥ OUT_N

## Operation
- **Input side**
  - Input i pushes {swb, tag} into FIFO i when upreq_i[i] & uprdy_o[i].
  - uprdy_o[i] = !full[i], and is driven from registered state only.
  - A beat whose swb is out of range (swb ≥ OUT_N) is accepted, then discarded at the FIFO head one cycle later, and sets err_o.
- **Arbitration**
  - FIFO head i requests output o when the FIFO is non-empty and head.swb == o.
  - Each output runs round-robin with pointer rr[o], which holds the last granted input. The search starts at rr[o]+1 and wraps at IN_N-1 back to 0.
  - rr[o] updates only on handshake (dnreq_o[o] & dnrdy_i[o]).
- **Grant stability**
  - When dnreq_o[o] is high and dnrdy_i[o] is low, the grant is latched in a hold register.
  - dnreq_o[o] and dntag_o[o] must not change until the handshake completes, even if a higher-priority head arrives.
- **Datapath and blocking**
  - dntag_o[o] = head tag of the granted input; 0 when dnreq_o[o] is low.
  - A FIFO pops on handshake at its granted output.
  - Head-of-line blocking is by design: a head stalled on output o blocks later beats destined for other outputs.
- Outputs never see duplicate or reordered beats from any single input.

## Timing
- Reset values:
  - uprdy_o = all 1s
  - dnreq_o = 0
  - dntag_o = 0
  - err_o = 0
  - FIFOs empty
  - rr[o] = IN_N-1, so input 0 has first priority
  - hold registers clear
- Latency: a beat accepted in cycle N can appear on dnreq_o in cycle N+1. There is no bypass path.
- Throughput: one beat per output per cycle. Each input pops at most one beat per cycle.
- Full FIFO: uprdy_o is low in the cycle after the push that fills it. It returns high in the cycle after a pop.
- Push and pop on the same FIFO in the same cycle: occupancy is unchanged.
- Empty FIFO: the input makes no request and is skipped by every arbiter.
- Simultaneous requests: input 1 & input 3 both target output 0 with rr[0] = 1 → input 3 wins.
- Reset asserted mid-operation: all state clears immediately, and in-flight beats are lost.

## Configuration
- SW_PKT_LOCK_EN defined:
  - uptag_i[TAG_W-1] is the last-beat flag.
  - Once an output grants input i for a non-last beat, it stays locked to i until a beat with last = 1 handshakes.
  - Other inputs are not granted that output during the lock, even while input i's FIFO is empty; dnreq_o stays low in those cycles.
  - The lock releases after the last-beat handshake, and rr then updates.
- SW_PKT_LOCK_EN undefined: arbitration runs per beat, and TAG_W-1 is ordinary payload.

## Structure
- Package sw_pkg holds:
  - the FIFO entry struct {swb, tag}
  - the round-robin next-index function (pointer, request vector → grant index and one-hot grant)
- Sub-module sw_fifo: synchronous FIFO of DEPTH entries.
  - Ports: clk, rst_n, push, pop, din, dout, empty, full.
  - Count width is $clog2(DEPTH)+1.
  - Pointers wrap modulo DEPTH.
- The top level instantiates IN_N copies of sw_fifo, plus OUT_N arbiters with their hold and lock registers in generate loops.

## Test plan
- **Single path:** in0 sends tag 0xA5 with swb = 2, dnrdy_i all high → dnreq_o[2] high next cycle with dntag_o[2] = 0xA5; no other dnreq_o asserted.
- **Fairness:** inputs 0..4 all stream to output 1, dnrdy_i[1] = 1 → grants rotate 0, 1, 2, 3, 4, 0, … with one beat per cycle.
- **Back-pressure / fill:** DEPTH = 4, dnrdy_i[0] = 0, in2 pushes 4 beats to output 0 → uprdy_o[2] is low on the 5th cycle. Release dnrdy_i → 4 beats arrive in order, and uprdy_o[2] rises the cycle after the first pop.
- **Grant stability:** output 3 is stalled with in4 granted, then in0 arrives targeting output 3 → dnreq_o[3] and dntag_o[3] hold in4's beat until dnrdy_i[3] = 1. In0 is granted next.
- **Error and reset:** OUT_N = 5, in1 sends swb = 7 → beat is dropped and err_o = 1 and stays 1. Assert rst_n low mid-stream → all outputs return to their reset values asynchronously.
- **With SW_PKT_LOCK_EN:** in0 sends a 3-beat packet to output 0 while in1 also requests output 0 → output 0 carries in0's 3 beats back to back, then in1.
